// File: rtl/register_bank_pkg.sv
// Shared operation codes for the register bank and its cells.
// Values are fixed by the datapath decode, so callers compare against these names only.
package register_bank_pkg;

    typedef logic [2:0] funsel_t;

    localparam funsel_t FS_DEC        = 3'b000;
    localparam funsel_t FS_INC        = 3'b001;
    localparam funsel_t FS_LOAD       = 3'b010;
    localparam funsel_t FS_CLR        = 3'b011;
    localparam funsel_t FS_LDLO_CLRHI = 3'b100;
    localparam funsel_t FS_LDLO       = 3'b101;
    localparam funsel_t FS_LDHI       = 3'b110;
    localparam funsel_t FS_HOLD       = 3'b111;

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit register with a sticky wrap flag; updates on the clock edge when enabled.
// Latency: one cycle. No backpressure: every enabled edge is accepted.
module register_cell
    import register_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    input  logic             WrapClr,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);

    localparam int               H   = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap_evt;

    always_comb begin
        w_next = r_q;
        case (FunSel)
            FS_DEC:        w_next = r_q - ONE;
            FS_INC:        w_next = r_q + ONE;
            FS_LOAD:       w_next = I;
            FS_CLR:        w_next = '0;
            FS_LDLO_CLRHI: w_next = {{(WIDTH-H){1'b0}}, I[H-1:0]};
            FS_LDLO:       w_next = {r_q[WIDTH-1:H], I[H-1:0]};
            FS_LDHI:       w_next = {I[H-1:0], r_q[H-1:0]};
            FS_HOLD:       w_next = r_q;
        endcase
    end

    // Only arithmetic roll-over raises the flag; loads and clears never touch it.
    assign w_wrap_evt = E & (((FunSel == FS_INC) & (&r_q)) |
                             ((FunSel == FS_DEC) & (r_q == '0)));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            if (E) begin
                r_q <= w_next;
            end
            r_wrap <= (r_wrap & ~WrapClr) | w_wrap_evt;
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule

// File: rtl/register_bank.sv
// DEPTH general-purpose registers with per-register enables and two combinational read ports.
// Latency: writes visible one cycle after the edge; reads are same-cycle. No backpressure.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    input  logic             WrapClr,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [DEPTH-1:0] Wrap
);

    logic [WIDTH-1:0] w_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_cell
        register_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .Clock   (Clock),
            .Reset   (Reset),
            .E       (RegSel[k]),
            .FunSel  (FunSel),
            .I       (I),
            .WrapClr (WrapClr),
            .Q       (w_q[k]),
            .Wrap    (Wrap[k])
        );
    end

    // Selects with no matching register fall through to zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (OutASel == k[SEL_W-1:0]) OutA = w_q[k];
            if (OutBSel == k[SEL_W-1:0]) OutB = w_q[k];
        end
    end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised bank of DEPTH general-purpose registers, each WIDTH bits wide. It is the generalised successor to the fixed 16-bit single register.
- Each register accepts the same decrement, increment, load and clear operations, plus half-word loads and a hold mode.
- Each register has a sticky wrap flag.
- Two combinational read ports feed the ALU operand muxes. This is the register-file slot of the CPU datapath.

Parameters:
- WIDTH, 16, register width in bits; must be even and ≥4.
- DEPTH, 4, number of registers; 2..16.
- RESET_VAL, 0, value loaded into every register on Reset.
- SEL_W, derived localparam = $clog2(DEPTH), width of the read selects.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high; clears the whole bank on the rising edge.
- RegSel  input  DEPTH  per-register enable mask; bit k enables register k; any number of bits may be set.
- FunSel  input  3  operation applied to every enabled register.
- I  input  WIDTH  load data.
- WrapClr  input  1  clears all sticky wrap flags.
- OutASel  input  SEL_W  read port A select.
- OutBSel  input  SEL_W  read port B select.
- OutA  output  WIDTH  contents of register OutASel.
- OutB  output  WIDTH  contents of register OutBSel.
- Wrap  output  DEPTH  sticky wrap flag per register.

Behaviour:
- Interface: one clock, Clock. Reset is synchronous and active-high.
- Reset has priority over everything. On the Reset edge: all registers ← RESET_VAL and Wrap ← 0, regardless of RegSel, FunSel or WrapClr.
- Without Reset, register k updates only when RegSel[k]=1. Otherwise it holds, and its Wrap bit changes only via WrapClr.
- FunSel encoding, H = WIDTH/2:
  - 000 dec: R ← R−1, modulo 2^WIDTH.
  - 001 inc: R ← R+1, modulo 2^WIDTH.
  - 010 load: R ← I.
  - 011 clear: R ← 0.
  - 100 load low, clear high: R ← {H'0, I[H-1:0]}.
  - 101 load low, keep high: R ← {R[WIDTH-1:H], I[H-1:0]}.
  - 110 load high, keep low: R ← {I[H-1:0], R[H-1:0]}. The low half of I is written to the upper half.
  - 111 hold: R unchanged. This is a no-op even when enabled.
- Latency: one cycle. A result is visible on OutA/OutB in the cycle after the edge.
- Read ports are purely combinational from current register state. There is no write-through: the read in the update cycle shows the pre-update value.
- Read selects ≥ DEPTH (possible when DEPTH is not a power of 2) drive all zeros. Both ports may select the same register.
- Wrap[k] sets on an edge where register k is enabled and either:
  - FunSel=001 and R = all-ones (becomes 0), or
  - FunSel=000 and R = 0 (becomes all-ones).
- Wrap is sticky: it stays set until WrapClr=1 or Reset.
- WrapClr=1 clears all Wrap bits on the edge. If a new wrap event occurs on the same edge, the set wins for that register.
- Loads and clears never set or clear Wrap.
- Simultaneous multi-register updates are independent. Each enabled register applies FunSel to its own value.
- Reset asserted mid-sequence (e.g. during an increment run) overrides that cycle's operation completely. The operation resumes only from RESET_VAL afterwards.

Decomposition:
- Package register_bank_pkg holds:
  - the FunSel localparams: FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LDLO_CLRHI, FS_LDLO, FS_LDHI, FS_HOLD;
  - a typedef for the 3-bit funsel_t.
- One sub-module, register_cell, holds one WIDTH register plus its wrap flip-flop. Its ports are Clock, Reset, E, FunSel, I, WrapClr, Q and Wrap. register_bank instantiates it DEPTH times in a generate loop.
- The read muxes live in the top module.

Test Plan:
- Reset and load:
  - Assert Reset for 1 cycle with RegSel=4'b1111, FunSel=010, I=16'hFFFF → all registers 0 and Wrap=0.
  - Then RegSel=4'b0100, FunSel=010, I=16'hBEEF, OutASel=2 → OutA=16'hBEEF one cycle later; OutB (sel 1)=0.
- Wrap on increment:
  - R1=16'hFFFF, FunSel=001, RegSel=4'b0010 → R1=0, Wrap=4'b0010.
  - Next cycle inc again → R1=1, Wrap still 4'b0010.
  - WrapClr=1 → Wrap=0.
- Wrap on decrement with a racing WrapClr:
  - R0=0, FunSel=000, RegSel=4'b0001, WrapClr=1 on the same edge → R0=16'hFFFF, Wrap[0]=1 (set wins).
- Half-word loads, starting from R3=16'h1234 with I=16'h00AB:
  - FunSel=101 → R3=16'h12AB.
  - FunSel=110 → 16'hAB34.
  - FunSel=100 → 16'h00AB.
  - FunSel=111 → unchanged.
- Multi-register update:
  - Start R0=5, R1=0, R2=7.
  - RegSel=4'b0111, FunSel=001 → R0=6, R1=1, R2=8, R3 unchanged.
  - During the update edge, OutA (sel 0) still reads 5.
- Reset mid-run and out-of-range select:
  - Run inc on R2 for 3 cycles, assert Reset on the 4th edge → R2=RESET_VAL, Wrap=0.
  - With DEPTH=3 and OutBSel=3 → OutB=0.
